seg7_scan_display: RTL and testbench

- Output-side board interface: drives the 8-digit multiplexed seven-segment display from a 32-bit value supplied by the CPU/debug display path.
- Latches the value on a load strobe and scans digits with a programmable prescaler.
- Hex-decodes each nibble and drives active-low anodes and segments.
- Supports leading-zero blanking and a per-digit enable mask. The displayed value changes only at frame boundaries (no tearing).

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_scan_display_if.sv | 25 ++
 rtl/seg7_scan_display_hex_to_seg7.sv | 14 +
 rtl/seg7_scan_display.sv | 125 ++++++++++++
 tb/tb_seg7_scan_display.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment table for the seven-segment scan display.
package seg7_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned NIBBLE_W   = 4;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned VALUE_W    = NUM_DIGITS * NIBBLE_W;

   localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
   localparam logic [NUM_DIGITS-1:0] AN_OFF    = 8'hFF;

   // Active-low segment patterns {g,f,e,d,c,b,a}, entry n = glyph for nibble n.
   localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/seg7_scan_display_if.sv
// Display bus: value/control from the CPU side, scanned anode/segment drive out.
interface seg7_scan_display_if;
   import seg7_pkg::*;

   logic                  load;
   logic [VALUE_W-1:0]    value;
   logic [NUM_DIGITS-1:0] dp;
   logic [NUM_DIGITS-1:0] digit_en;
   logic                  blank_lz;
   logic [NUM_DIGITS-1:0] an;
   logic [SEG_W-1:0]      seg;
   logic                  dp_n;
   logic                  frame_done;

   modport master (
      output load, value, dp, digit_en, blank_lz,
      input  an, seg, dp_n, frame_done
   );

   modport slave (
      input  load, value, dp, digit_en, blank_lz,
      output an, seg, dp_n, frame_done
   );

endinterface

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [NIBBLE_W-1:0] nibble,
   output logic [SEG_W-1:0]    seg
);

   // Table lookup of the glyph for the nibble.
   always_comb begin
      seg = HEX_SEG[nibble];
   end

endmodule

// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed seven-segment driver with frame-synchronous value update.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int unsigned SCAN_DIV   = 100000,
   parameter int unsigned NUM_DIGITS = 8
)(
   input logic                clk,
   input logic                rst_n,
   seg7_scan_display_if.slave bus
);

   localparam int unsigned PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam logic [PW-1:0]    PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   logic [PW-1:0]         presc;
   logic [IDX_W-1:0]      idx;
   logic                  tc;
   logic                  wrap;

   logic [VALUE_W-1:0]    shadow_val;
   logic [NUM_DIGITS-1:0] shadow_dp;
   logic [VALUE_W-1:0]    disp_val;
   logic [NUM_DIGITS-1:0] disp_dp;

   logic [NUM_DIGITS-1:0] upper_zero;
   logic [NIBBLE_W-1:0]   cur_nib;
   logic [SEG_W-1:0]      dec_seg;
   logic                  dark;

   logic [NUM_DIGITS-1:0] an_q;
   logic [SEG_W-1:0]      seg_q;
   logic                  dp_n_q;
   logic                  frame_done_q;

   assign tc   = (presc == PRESC_LAST);
   assign wrap = tc && (idx == IDX_LAST);

   // Digit dwell prescaler and scan index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= '0;
      end else if (tc) begin
         presc <= '0;
         idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Shadow capture on load; display copy only at the frame wrap so a frame never tears.
   // A load landing on the wrap edge bypasses the shadow so it is not lost for a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_val <= '0;
         shadow_dp  <= '0;
         disp_val   <= '0;
         disp_dp    <= '0;
      end else begin
         if (bus.load) begin
            shadow_val <= bus.value;
            shadow_dp  <= bus.dp;
         end
         if (wrap) begin
            disp_val <= bus.load ? bus.value : shadow_val;
            disp_dp  <= bus.load ? bus.dp    : shadow_dp;
         end
      end
   end

   // upper_zero[i] is set when display nibbles i..top are all zero.
   always_comb begin
      logic        acc;
      int unsigned i;
      acc        = 1'b1;
      upper_zero = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         i             = NUM_DIGITS - 1 - k;
         acc           = acc && (disp_val[i*NIBBLE_W +: NIBBLE_W] == '0);
         upper_zero[i] = acc;
      end
   end

   // Current digit nibble and dark decision (disabled or leading-zero blanked).
   always_comb begin
      cur_nib = disp_val[{idx, 2'b00} +: NIBBLE_W];
      dark    = !bus.digit_en[idx] ||
                (bus.blank_lz && (idx != '0) && upper_zero[idx]);
   end

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (cur_nib),
      .seg    (dec_seg)
   );

   // Registered anode/segment/dp drive and frame pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q         <= AN_OFF;
         seg_q        <= SEG_BLANK;
         dp_n_q       <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= wrap;
         if (dark) begin
            an_q   <= AN_OFF;
            seg_q  <= SEG_BLANK;
            dp_n_q <= 1'b1;
         end else begin
            an_q   <= ~(NUM_DIGITS'(1) << idx);
            seg_q  <= dec_seg;
            dp_n_q <= ~disp_dp[idx];
         end
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp_n       = dp_n_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Randomised self-checking bench for seg7_scan_display against a frame-level model.
module tb_seg7_scan_display;

   localparam int unsigned SD    = 4;
   localparam int unsigned FRAME = 8 * SD;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   seg7_scan_display_if bus_if ();

   seg7_scan_display #(
      .SCAN_DIV   (SD),
      .NUM_DIGITS (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   int checks = 0;
   int errors = 0;

   // Model state: edges since reset release, shadow and displayed frame.
   int unsigned cyc;
   logic [31:0] m_sh_val, m_dv;
   logic [7:0]  m_sh_dp,  m_ddp;
   logic [7:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dpn, e_fd;

   function automatic logic [6:0] ref_glyph(input int unsigned n);
      case (n)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
        12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      cyc      = 0;
      m_sh_val = '0;
      m_sh_dp  = '0;
      m_dv     = '0;
      m_ddp    = '0;
      e_an     = 8'hFF;
      e_seg    = 7'h7F;
      e_dpn    = 1'b1;
      e_fd     = 1'b0;
   endtask

   // One clock edge of the reference: what the outputs show after this edge.
   task automatic model_step();
      int unsigned d;
      int unsigned nib;
      bit          boundary;
      bit          lz;
      bit          dk;
      d        = (cyc / SD) % 8;
      boundary = ((cyc % FRAME) == FRAME - 1);
      nib      = (m_dv >> (4 * d)) & 32'hF;
      lz       = bus_if.blank_lz && (d > 0) && ((m_dv >> (4 * d)) == 0);
      dk       = !bus_if.digit_en[d] || lz;
      e_an     = dk ? 8'hFF : ~(8'(1) << d);
      e_seg    = dk ? 7'h7F : ref_glyph(nib);
      e_dpn    = dk ? 1'b1  : !m_ddp[d];
      e_fd     = boundary;
      if (bus_if.load) begin
         m_sh_val = bus_if.value;
         m_sh_dp  = bus_if.dp;
      end
      if (boundary) begin
         m_dv  = m_sh_val;
         m_ddp = m_sh_dp;
      end
      cyc++;
   endtask

   task automatic check_outputs();
      check("an",         32'(bus_if.an),         32'(e_an));
      check("seg",        32'(bus_if.seg),        32'(e_seg));
      check("dp_n",       32'(bus_if.dp_n),       32'(e_dpn));
      check("frame_done", 32'(bus_if.frame_done), 32'(e_fd));
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic run(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) tick();
   endtask

   task automatic pulse_load(input logic [31:0] v, input logic [7:0] d);
      bus_if.value = v;
      bus_if.dp    = d;
      bus_if.load  = 1'b1;
      tick();
      bus_if.load  = 1'b0;
   endtask

   // Advance until the current cycle sits at the given position in the frame.
   task automatic wait_phase(input int unsigned p);
      int unsigned budget;
      budget = 2 * FRAME;
      while (((cyc % FRAME) != p) && (budget > 0)) begin
         tick();
         budget--;
      end
      if (budget == 0) check("wait_phase_timeout", 32'(cyc % FRAME), 32'(p));
   endtask

   task automatic wait_digit(input int unsigned dg);
      int unsigned budget;
      budget = 2 * FRAME;
      while ((((cyc / SD) % 8) != dg) && (budget > 0)) begin
         tick();
         budget--;
      end
      if (budget == 0) check("wait_digit_timeout", 32'((cyc / SD) % 8), 32'(dg));
   endtask

   initial begin
      bus_if.load     = 1'b0;
      bus_if.value    = '0;
      bus_if.dp       = '0;
      bus_if.digit_en = 8'hFF;
      bus_if.blank_lz = 1'b1;
      model_reset();

      // Reset held, with a load strobe that must be ignored.
      #1 rst_n = 1'b0;
      #1 check_outputs();
      bus_if.value = 32'hDEADBEEF;
      bus_if.dp    = 8'hFF;
      bus_if.load  = 1'b1;
      run(3);
      bus_if.load  = 1'b0;
      rst_n = 1'b1;

      // Idle scan of a zero value with leading-zero blanking.
      run(40);

      // New value becomes visible only from the next frame.
      bus_if.blank_lz = 1'b0;
      pulse_load(32'h1234ABCD, 8'h00);
      run(70);

      // Leading-zero blanking on and off.
      bus_if.blank_lz = 1'b1;
      pulse_load(32'h000000F0, 8'h00);
      run(70);
      bus_if.blank_lz = 1'b0;
      run(40);

      // Load on the wrap edge goes straight to display; one cycle later waits a frame.
      wait_phase(FRAME - 1);
      pulse_load(32'h00000005, 8'h00);
      run(40);
      wait_phase(0);
      pulse_load(32'h00000007, 8'h01);
      run(70);

      // Digit 0 disabled, decimal point on digit 1.
      bus_if.digit_en = 8'b1111_1110;
      pulse_load(32'h00000012, 8'h02);
      run(70);

      // Randomised loads and live-control changes.
      for (int unsigned k = 0; k < 600; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            bus_if.value = $urandom >> $urandom_range(0, 31);
            bus_if.dp    = 8'($urandom);
            bus_if.load  = 1'b1;
         end else begin
            bus_if.load  = 1'b0;
         end
         if ($urandom_range(0, 19) == 0) begin
            bus_if.digit_en = 8'($urandom) | 8'($urandom);
            bus_if.blank_lz = 1'($urandom);
         end
         tick();
      end
      bus_if.load = 1'b0;

      // Asynchronous reset in the middle of digit 5.
      bus_if.digit_en = 8'hFF;
      bus_if.blank_lz = 1'b0;
      pulse_load(32'h89ABCDEF, 8'hFF);
      run(FRAME);
      wait_digit(5);
      tick();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_outputs();
      run(2);
      rst_n = 1'b1;
      run(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run cannot hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
